// File: rtl/axi_rb_pkg.sv
// Shared types and constants for the AXI read-burst arbiter.
// Holds the FSM state encoding and the AXI burst/size helpers.
package axi_rb_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic [1:0] {
      IDLE,
      AR,
      DATA
   } state_t;

   function automatic logic [2:0] arsize_f(input int dw);
      logic [2:0] s;
      s = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if ((1 << i) == (dw / 8)) begin
            s = 3'(i);
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans upward from start, wrapping, first requester wins.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      start,
   output logic [NREQ-1:0] gnt,
   output logic [2:0]      idx,
   output logic            any
);

   // lowest index at/above start, else lowest index below start
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!any && req[i] && (i >= int'(start))) begin
            any    = 1'b1;
            idx    = 3'(i);
            gnt[i] = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!any && req[i] && (i < int'(start))) begin
            any    = 1'b1;
            idx    = 3'(i);
            gnt[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read port between NREQ burst requesters.
// One INCR burst outstanding; R beats steered to the grantee.
module axi_rd_arbiter
   import axi_rb_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NREQ*8-1:0]          req_len,
   output logic [DATA_WIDTH-1:0]      rsp_data,
   output logic [NREQ-1:0]            rsp_valid,
   input  logic [NREQ-1:0]            rsp_ready,
   output logic                       rsp_last,
   output logic [ADDR_WIDTH-1:0]      s_axi_araddr,
   output logic [7:0]                 s_axi_arlen,
   output logic [2:0]                 s_axi_arsize,
   output logic [1:0]                 s_axi_arburst,
   output logic                       s_axi_arvalid,
   input  logic                       s_axi_arready,
   input  logic [DATA_WIDTH-1:0]      s_axi_rdata,
   input  logic                       s_axi_rvalid,
   output logic                       s_axi_rready,
   output logic                       busy,
   output logic [2:0]                 grant
);

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            cnt_q;
   logic [2:0]            grant_q;
   logic [2:0]            ptr_q;

   logic [NREQ-1:0]       gnt;
   logic [2:0]            gidx;
   logic                  any;
   logic                  accept;
   logic                  beat;
   logic                  final_beat;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [7:0]            sel_len;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr (
      .req   (req_valid),
      .start (ptr_q),
      .gnt   (gnt),
      .idx   (gidx),
      .any   (any)
   );

   // pick the winner's address and length out of the packed buses
   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_len  = req_len[i*8 +: 8];
         end
      end
   end

   // next state plus handshake and steering outputs
   always_comb begin
      state_d       = state_q;
      req_ready     = '0;
      rsp_valid     = '0;
      rsp_last      = 1'b0;
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b0;
      accept        = 1'b0;
      beat          = 1'b0;
      final_beat    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any && !rst) begin
               req_ready = gnt;
               accept    = 1'b1;
               state_d   = AR;
            end
         end
         AR: begin
            s_axi_arvalid = 1'b1;
            if (s_axi_arready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            for (int i = 0; i < NREQ; i++) begin
               if (grant_q == 3'(i)) begin
                  rsp_valid[i] = s_axi_rvalid;
                  s_axi_rready = rsp_ready[i];
               end
            end
            rsp_last   = (cnt_q == len_q);
            beat       = s_axi_rvalid && s_axi_rready;
            final_beat = beat && rsp_last;
            if (final_beat) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // burst descriptor latch, beat counter and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         if (accept) begin
            addr_q  <= sel_addr;
            len_q   <= sel_len;
            grant_q <= gidx;
         end
         if (final_beat) begin
            cnt_q <= '0;
            if (grant_q == 3'(NREQ - 1)) begin
               ptr_q <= '0;
            end else begin
               ptr_q <= grant_q + 3'd1;
            end
         end else if (beat) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

   assign rsp_data      = s_axi_rdata;
   assign s_axi_araddr  = addr_q;
   assign s_axi_arlen   = len_q;
   assign s_axi_arsize  = arsize_f(DATA_WIDTH);
   assign s_axi_arburst = AXI_BURST_INCR;
   assign busy          = (state_q != IDLE);
   assign grant         = grant_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter (NREQ=2, 16-bit addr, 32-bit data).
// Stimulus pushes expected AR/R items; a monitor pops and compares.
module tb_axi_rd_arbiter;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  len;
   } rq_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  len;
      logic [2:0]  g;
   } ar_t;

   typedef struct {
      logic [1:0]  g;
      logic [31:0] data;
      logic        last;
   } bt_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_addr;
   logic [15:0] req_len;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic        rsp_last;
   logic [15:0] s_axi_araddr;
   logic [7:0]  s_axi_arlen;
   logic [2:0]  s_axi_arsize;
   logic [1:0]  s_axi_arburst;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic        busy;
   logic [2:0]  grant;

   int checks = 0;
   int failures = 0;
   int beats_seen = 0;
   int ar_delay = 0;
   bit rr_toggle = 0;
   bit force_rv = 0;

   rq_t rq0[$];
   rq_t rq1[$];
   ar_t arq[$];
   bt_t bq[$];

   axi_rd_arbiter #(
      .NREQ       (2),
      .ADDR_WIDTH (16),
      .DATA_WIDTH (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_len       (req_len),
      .rsp_data      (rsp_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_last      (rsp_last),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arlen   (s_axi_arlen),
      .s_axi_arsize  (s_axi_arsize),
      .s_axi_arburst (s_axi_arburst),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .busy          (busy),
      .grant         (grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // queue one burst for requester g and its expected AR + beats
   task automatic burst(input int g, input logic [15:0] addr,
                        input logic [7:0] len);
      rq_t r;
      ar_t a;
      bt_t b;
      r.addr = addr;
      r.len  = len;
      if (g == 0) rq0.push_back(r);
      else rq1.push_back(r);
      a.addr = addr;
      a.len  = len;
      a.g    = 3'(g);
      arq.push_back(a);
      for (int i = 0; i <= int'(len); i++) begin
         b.g    = 2'(g);
         b.data = {16'h0, addr} + 32'(i);
         b.last = (i == int'(len));
         bq.push_back(b);
      end
   endtask

   task automatic wait_done(input int budget, input string nm);
      int n;
      n = 0;
      while ((arq.size() != 0 || bq.size() != 0 || busy) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s_timeout: got arq=%0d bq=%0d busy=%0b expected drained",
                  nm, arq.size(), bq.size(), busy);
      end
   endtask

   // requester agents: hold head of queue until accepted
   initial begin
      logic [1:0] acc;
      req_valid = '0;
      req_addr  = '0;
      req_len   = '0;
      forever begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
         if (acc[0] && rq0.size() > 0) void'(rq0.pop_front());
         if (acc[1] && rq1.size() > 0) void'(rq1.pop_front());
         req_valid[0]   = rq0.size() > 0;
         req_valid[1]   = rq1.size() > 0;
         req_addr[15:0]  = rq0.size() > 0 ? rq0[0].addr : 16'h0;
         req_len[7:0]    = rq0.size() > 0 ? rq0[0].len : 8'h0;
         req_addr[31:16] = rq1.size() > 0 ? rq1[0].addr : 16'h0;
         req_len[15:8]   = rq1.size() > 0 ? rq1[0].len : 8'h0;
      end
   end

   // AXI slave: data = start address + beat index
   initial begin
      bit          ar_hs, r_hs, rst_s, arv, phase;
      logic [15:0] cap_addr, sl_addr;
      logic [7:0]  cap_len, sl_len;
      int          sl_beat, ar_cnt;
      bit          sl_act;
      phase = 0; sl_act = 0; sl_beat = 0; ar_cnt = 0;
      sl_addr = '0; sl_len = '0;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      s_axi_rdata   = '0;
      rsp_ready     = 2'b11;
      forever begin
         @(negedge clk);
         ar_hs    = s_axi_arvalid && s_axi_arready;
         r_hs     = s_axi_rvalid && s_axi_rready;
         rst_s    = rst;
         arv      = s_axi_arvalid;
         cap_addr = s_axi_araddr;
         cap_len  = s_axi_arlen;
         @(posedge clk);
         #1;
         if (rst_s) begin
            sl_act = 0;
            ar_cnt = 0;
            sl_beat = 0;
         end else begin
            if (ar_hs) begin
               sl_act  = 1;
               sl_addr = cap_addr;
               sl_len  = cap_len;
               sl_beat = 0;
               ar_cnt  = 0;
            end else if (arv) begin
               ar_cnt++;
            end
            if (r_hs && sl_act) begin
               if (sl_beat == int'(sl_len)) sl_act = 0;
               else sl_beat++;
            end
         end
         phase = !phase;
         s_axi_arready = s_axi_arvalid && (ar_cnt >= ar_delay);
         s_axi_rvalid  = sl_act || force_rv;
         s_axi_rdata   = {16'h0, sl_addr} + 32'(sl_beat);
         rsp_ready     = rr_toggle ? {2{phase}} : 2'b11;
      end
   end

   // monitor: AR rules and scoreboard pops on handshakes
   initial begin
      bit          prev_wait;
      logic [15:0] prev_addr;
      ar_t         a;
      bt_t         b;
      prev_wait = 0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_wait = 0;
         end else begin
            if (prev_wait) begin
               chk("arvalid_hold", 64'(s_axi_arvalid), 64'd1);
               chk("araddr_hold", 64'(s_axi_araddr), 64'(prev_addr));
            end
            if (s_axi_arvalid) begin
               chk("ar_rready_low", 64'(s_axi_rready), 64'd0);
               chk("ar_rsp_valid_low", 64'(rsp_valid), 64'd0);
            end
            prev_wait = s_axi_arvalid && !s_axi_arready;
            prev_addr = s_axi_araddr;
            if (s_axi_arvalid && s_axi_arready) begin
               if (arq.size() == 0) begin
                  chk("ar_unexpected", 64'(s_axi_araddr), 64'hffff_ffff);
               end else begin
                  a = arq.pop_front();
                  chk("araddr", 64'(s_axi_araddr), 64'(a.addr));
                  chk("arlen", 64'(s_axi_arlen), 64'(a.len));
                  chk("ar_grant", 64'(grant), 64'(a.g));
               end
            end
            if (s_axi_rvalid && s_axi_rready) begin
               beats_seen++;
               if (bq.size() == 0) begin
                  chk("beat_unexpected", 64'(rsp_data), 64'hffff_ffff);
               end else begin
                  b = bq.pop_front();
                  chk("rsp_valid", 64'(rsp_valid), 64'(2'b01 << b.g));
                  chk("rsp_data", 64'(rsp_data), 64'(b.data));
                  chk("rsp_last", 64'(rsp_last), 64'(b.last));
               end
            end
         end
      end
   end

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_arvalid"}, 64'(s_axi_arvalid), 64'd0);
      chk({nm, "_rready"}, 64'(s_axi_rready), 64'd0);
      chk({nm, "_req_ready"}, 64'(req_ready), 64'd0);
      chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({nm, "_rsp_last"}, 64'(rsp_last), 64'd0);
      chk({nm, "_grant"}, 64'(grant), 64'd0);
      chk({nm, "_araddr"}, 64'(s_axi_araddr), 64'd0);
      chk({nm, "_arlen"}, 64'(s_axi_arlen), 64'd0);
   endtask

   initial begin
      int base, n;
      rst = 1'b1;
      // contention: both requesters pending from reset, two bursts each
      burst(0, 16'h1000, 8'd1);
      burst(1, 16'h2000, 8'd0);
      burst(0, 16'h1100, 8'd1);
      burst(1, 16'h2100, 8'd2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      chk("arsize", 64'(s_axi_arsize), 64'd2);
      chk("arburst", 64'(s_axi_arburst), 64'd1);
      step();
      rst = 1'b0;
      wait_done(200, "contention");
      chk("contention_last_grant", 64'(grant), 64'd1);

      // single request, everything ready
      burst(0, 16'h0100, 8'd3);
      wait_done(100, "single");
      chk("single_busy", 64'(busy), 64'd0);
      chk("single_grant", 64'(grant), 64'd0);

      // AR stall and rsp_ready toggling
      ar_delay  = 5;
      rr_toggle = 1;
      burst(1, 16'h0001, 8'd3);
      wait_done(200, "backpressure");
      ar_delay  = 0;
      rr_toggle = 0;

      // maximum length burst
      burst(0, 16'h4000, 8'd255);
      wait_done(1000, "len255");
      chk("len255_busy", 64'(busy), 64'd0);

      // rvalid asserted while still in AR
      force_rv = 1;
      ar_delay = 3;
      burst(1, 16'h0500, 8'd2);
      wait_done(100, "rv_in_ar");
      force_rv = 0;
      ar_delay = 0;

      // reset in the middle of an 8-beat burst
      burst(0, 16'h0600, 8'd7);
      base = beats_seen;
      n = 0;
      while (beats_seen < base + 2 && n < 100) begin
         step();
         n++;
      end
      chk("midreset_reach_beat2", 64'(beats_seen >= base + 2), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("midreset");
      arq.delete();
      bq.delete();
      step();
      rst = 1'b0;
      burst(1, 16'h0700, 8'd1);
      wait_done(100, "after_reset");
      chk("after_reset_grant", 64'(grant), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
